serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands shift LSB-first through one full-adder slice with a registered carry,
// valid/ready on both sides. Optional signed-overflow output `ovf` built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic s_bit, c_bit, last_bit;

    // Single full-adder slice; carry_q closes the ripple loop across clock edges.
    assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_bit    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = ci;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = c_bit;
            // Counter parks on the last index instead of wrapping; it is reloaded on the next accept.
            cnt_d    = last_bit ? cnt_q : cnt_q + 1'b1;
            if (last_bit) begin
                sum_d  = {s_bit, sum_sh_q[WIDTH-1:1]};
                cout_d = c_bit;
                ovf_d  = carry_q ^ c_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected {ovf,cout,sum} queued at accept, compared at out_valid.
// Overflow checks compile only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`else
    logic             ovf;
    assign ovf = 1'b0;
`endif

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    time last_accept_t;

    // {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #(PERIOD / 2) clk = ~clk;

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {v, full};
    endfunction

    // Waits for in_ready, presents operands for one accepting edge; optionally queues the expectation.
    task automatic drive_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                            input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
        ci       = c;
        if (push) exp_q.push_back(model(x, y, c));
        @(posedge clk);
        last_accept_t = $time;
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept until out_valid; optionally scrambles the inputs meanwhile.
    task automatic wait_out(input bit churn, output int lat, output bit timed_out);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (churn) begin
                if (out_valid) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    a        = WIDTH'($urandom);
                    b        = WIDTH'($urandom);
                    ci       = 1'($urandom);
                end
            end
        end
        timed_out = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0})
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, expected 1 0 00 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        else pass_cnt++;
    endtask

    task automatic check_result(input string name, input bit churn);
        int               lat;
        bit               to;
        logic [WIDTH+1:0] e;
        wait_out(churn, lat, to);
        e = exp_q.pop_front();
        total_cnt++;
        if (to || lat != WIDTH)
            $display("FAIL %s_latency: got %0d edges (timeout=%b), expected %0d", name, lat, to, WIDTH);
        else pass_cnt++;
        total_cnt++;
        if ({cout, sum} !== e[WIDTH:0])
            $display("FAIL %s_result: cout=%b sum=%h, expected cout=%b sum=%h", name, cout, sum,
                     e[WIDTH], e[WIDTH-1:0]);
        else pass_cnt++;
`ifdef SERIAL_ADDER_OVF_EN
        total_cnt++;
        if (ovf !== e[WIDTH+1])
            $display("FAIL %s_ovf: ovf=%b, expected %b", name, ovf, e[WIDTH+1]);
        else pass_cnt++;
`endif
        release_out();
        total_cnt++;
        if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, e[WIDTH:0]})
            $display("FAIL %s_handoff: out_valid=%b in_ready=%b cout=%b sum=%h, expected 0 1 %b %h",
                     name, out_valid, in_ready, cout, sum, e[WIDTH], e[WIDTH-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        drive_op(8'h35, 8'h4A, 1'b0, 1'b1);
        check_result("add_35_4a", 1'b0);
        drive_op(8'hFF, 8'h01, 1'b0, 1'b1);
        check_result("add_ff_01", 1'b0);
        drive_op(8'hFF, 8'h00, 1'b1, 1'b1);
        check_result("add_ff_00_ci", 1'b0);
        drive_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        check_result("add_ff_ff_ci", 1'b0);
        drive_op(8'h00, 8'h00, 1'b0, 1'b1);
        check_result("add_zero", 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
            check_result("add_rand", 1'b0);
        end
    endtask

    task automatic test_backpressure();
        int               lat;
        bit               to;
        logic [WIDTH+1:0] e;
        drive_op(8'h12, 8'h34, 1'b0, 1'b1);
        wait_out(1'b0, lat, to);
        e = exp_q.pop_front();
        total_cnt++;
        if (to || sum !== e[WIDTH-1:0])
            $display("FAIL bp_result: sum=%h timeout=%b, expected sum=%h", sum, to, e[WIDTH-1:0]);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, e[WIDTH:0]})
                $display("FAIL bp_stall: cycle %0d out_valid=%b in_ready=%b cout=%b sum=%h, expected 1 0 %b %h",
                         i, out_valid, in_ready, cout, sum, e[WIDTH], e[WIDTH-1:0]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        release_out();
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_churn();
        drive_op(8'h5C, 8'h27, 1'b1, 1'b1);
        check_result("churn_a", 1'b1);
        drive_op(8'hC3, 8'h9E, 1'b0, 1'b1);
        check_result("churn_b", 1'b1);
    endtask

    task automatic test_reset_midop();
        drive_op(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0})
            $display("FAIL midop_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, expected 1 0 00 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_op(8'h01, 8'h01, 1'b0, 1'b1);
        check_result("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        int               lat;
        bit               to;
        logic [WIDTH+1:0] e;
        time              prev_t;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prev_t = last_accept_t;
            drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
            if (i > 0) begin
                total_cnt++;
                if (last_accept_t - prev_t != (WIDTH + 2) * PERIOD)
                    $display("FAIL b2b_interval: got %0t, expected %0d", last_accept_t - prev_t,
                             (WIDTH + 2) * PERIOD);
                else pass_cnt++;
            end
            wait_out(1'b0, lat, to);
            e = exp_q.pop_front();
            total_cnt++;
            if (to || {cout, sum} !== e[WIDTH:0])
                $display("FAIL b2b_result: cout=%b sum=%h timeout=%b, expected cout=%b sum=%h", cout, sum, to,
                         e[WIDTH], e[WIDTH-1:0]);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        drive_op(8'h7F, 8'h01, 1'b0, 1'b1);
        check_result("ovf_7f_01", 1'b0);
        drive_op(8'hFF, 8'h01, 1'b0, 1'b1);
        check_result("ovf_ff_01", 1'b0);
        drive_op(8'h80, 8'h80, 1'b0, 1'b1);
        check_result("ovf_80_80", 1'b0);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        last_accept_t = 0;
        #(PERIOD * 2 + 1);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_backpressure();
        test_churn();
        test_reset_midop();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
